mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Generalised N-client arbiter between CPU-side requesters (prefetcher, scheduler, future DMA/debug clients) and the single serial memory_interface. It grants the TX channel to one client at a time, holds the grant for a whole transaction or reservation, and records reply-expecting transactions in an ordered ID FIFO. Each RX reply is then routed to the client that issued it. It sits between the clients and memory_interface inside the CPU top level.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (2..8); ID width CW = max(1, clog2(NUM_CLIENTS))
IO_BITS, 2, serial data width per cycle
CMD_BITS, 3, TX command header width
MAX_OUTSTANDING, 7, reply-tracking FIFO depth (1..15)
RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = round robin
DEFAULT_CLIENT, 0, owner of the TX channel when nobody requests it

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cl_tx_command_valid  in  NUM_CLIENTS  per-client command request
cl_tx_command  in  NUM_CLIENTS*CMD_BITS  per-client command; client i in slice [i*CMD_BITS +: CMD_BITS]
cl_tx_data  in  NUM_CLIENTS*IO_BITS  per-client payload nibble
cl_reply_wanted  in  NUM_CLIENTS  the client's current command expects an RX reply
cl_reserve  in  NUM_CLIENTS  keep the grant after the current transaction
tx_command_valid  out  1  to memory_interface
tx_command  out  CMD_BITS  to memory_interface
tx_data  out  IO_BITS  to memory_interface
tx_command_started, tx_active, tx_data_next, tx_done  in  1 each  from memory_interface
rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done  in  1 each  from memory_interface
cl_tx_command_started, cl_tx_active, cl_tx_data_next, cl_tx_done  out  NUM_CLIENTS each  gated TX events
cl_rx_started, cl_rx_active, cl_rx_sbs_valid, cl_rx_data_valid, cl_rx_done  out  NUM_CLIENTS each  routed RX events
grant_id  out  CW  current TX owner
outstanding  out  4  FIFO occupancy
fifo_full  out  1  occupancy == MAX_OUTSTANDING
rx_orphan  out  1  sticky: rx_started seen while FIFO empty

Behaviour:
- Reset: grant register = DEFAULT_CLIENT; RR pointer = DEFAULT_CLIENT; FIFO empty; outstanding = 0; rx_orphan = 0. All per-client outputs are 0 while the memory_interface inputs are 0.
- want[i] = cl_tx_command_valid[i] | cl_reserve[i].
- Channel locked = tx_active, or cl_reserve of the registered owner is high.
- Unlocked, combinational selection: fixed mode picks the highest i with want[i]; RR mode searches upward from RR pointer+1, with wrap. If no want, select DEFAULT_CLIENT. The grant register loads the selection every unlocked cycle.
- grant_id = locked ? register : selection. This gives zero-cycle grant on an idle channel; the owner is frozen while locked.
- tx_command_valid = cl_tx_command_valid[grant_id] & ~fifo_full. tx_command and tx_data are muxed from grant_id.
- cl_tx_*[i] = the corresponding input AND (grant_id == i).
- On tx_command_started, the RR pointer loads grant_id.
- FIFO push on tx_command_started & cl_reply_wanted[grant_id]; the entry is grant_id. Pop on rx_done when not empty.
- Simultaneous push and pop: occupancy unchanged, order preserved. If empty, the pushed entry is not visible at the head until the next cycle.
- cl_rx_*[i] = input AND ~empty AND (head == i). With an empty FIFO, all routed RX outputs are 0.
- fifo_full suppresses new commands. It does not abort an active transaction or a reservation.
- rx_started while empty sets rx_orphan until reset. rx_done while empty does not underflow.
- A reset mid-transaction clears state immediately (asynchronous). Outputs are valid in the first cycle after deassertion.

Test Plan:
- Fixed mode, NUM_CLIENTS=2, both valid at idle -> grant_id=1 in the same cycle; client 0 waits until tx_active falls.
- RR mode, NUM_CLIENTS=3, all valid, three back-to-back starts -> grant sequence 1,2,0 (pointer starting 0).
- Client 0 holds cl_reserve across two transactions while client 1 requests -> grant_id stays 0; client 1 is granted the cycle after reserve drops.
- Issue 7 reply-wanted reads with MAX_OUTSTANDING=7 -> fifo_full=1, tx_command_valid=0 despite a request; one rx_done -> outstanding=6 and valid reasserts.
- Interleave reads from clients 1,0,1 -> rx_* routed to 1, then 0, then 1; writes (cl_reply_wanted=0) leave outstanding unchanged.
- rx_started pulse with empty FIFO -> rx_orphan=1 and no cl_rx output; assert reset mid-transaction -> grant_id=DEFAULT_CLIENT, outstanding=0, rx_orphan=0 asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Grants the serial memory TX channel to one of N clients (zero-cycle on an idle channel, frozen while locked)
// and routes RX replies to their issuers via an ordered ID FIFO; a full FIFO withholds tx_command_valid.
module mem_port_arbiter #(
    parameter int NUM_CLIENTS     = 2,
    parameter int IO_BITS         = 2,
    parameter int CMD_BITS        = 3,
    parameter int MAX_OUTSTANDING = 7,
    parameter int RR_MODE         = 0,
    parameter int DEFAULT_CLIENT  = 0,
    localparam int CW = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          cl_tx_command_valid,
    input  logic [NUM_CLIENTS*CMD_BITS-1:0] cl_tx_command,
    input  logic [NUM_CLIENTS*IO_BITS-1:0]  cl_tx_data,
    input  logic [NUM_CLIENTS-1:0]          cl_reply_wanted,
    input  logic [NUM_CLIENTS-1:0]          cl_reserve,
    output logic                            tx_command_valid,
    output logic [CMD_BITS-1:0]             tx_command,
    output logic [IO_BITS-1:0]              tx_data,
    input  logic                            tx_command_started,
    input  logic                            tx_active,
    input  logic                            tx_data_next,
    input  logic                            tx_done,
    input  logic                            rx_started,
    input  logic                            rx_active,
    input  logic                            rx_sbs_valid,
    input  logic                            rx_data_valid,
    input  logic                            rx_done,
    output logic [NUM_CLIENTS-1:0]          cl_tx_command_started,
    output logic [NUM_CLIENTS-1:0]          cl_tx_active,
    output logic [NUM_CLIENTS-1:0]          cl_tx_data_next,
    output logic [NUM_CLIENTS-1:0]          cl_tx_done,
    output logic [NUM_CLIENTS-1:0]          cl_rx_started,
    output logic [NUM_CLIENTS-1:0]          cl_rx_active,
    output logic [NUM_CLIENTS-1:0]          cl_rx_sbs_valid,
    output logic [NUM_CLIENTS-1:0]          cl_rx_data_valid,
    output logic [NUM_CLIENTS-1:0]          cl_rx_done,
    output logic [CW-1:0]                   grant_id,
    output logic [3:0]                      outstanding,
    output logic                            fifo_full,
    output logic                            rx_orphan
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] DEF_ID    = CW'(DEFAULT_CLIENT);
    localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

    logic [NUM_CLIENTS-1:0] want;
    logic [NUM_CLIENTS-1:0] gnt_sel;
    logic [NUM_CLIENTS-1:0] head_sel;
    logic [CW-1:0]          grant_q;
    logic [CW-1:0]          rr_ptr_q;
    logic [CW-1:0]          sel_id;
    logic [CW-1:0]          head_id;
    logic                   locked;
    logic                   found;
    int                     idx;
    logic                   valid_sel;
    logic                   reply_sel;

    logic [CW-1:0]          fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [3:0]             count_q;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    assign want   = cl_tx_command_valid | cl_reserve;
    assign locked = tx_active | cl_reserve[grant_q];

    // Round robin scans upward from the last started client, so the pointer itself is tried last.
    always_comb begin
        sel_id = DEF_ID;
        found  = 1'b0;
        idx    = 0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
                if (!found && want[CW'(idx)]) begin
                    sel_id = CW'(idx);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (want[i]) sel_id = CW'(i);
            end
        end
    end

    assign grant_id = locked ? grant_q : sel_id;

    always_comb begin
        gnt_sel    = '0;
        head_sel   = '0;
        tx_command = '0;
        tx_data    = '0;
        valid_sel  = 1'b0;
        reply_sel  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            gnt_sel[i]  = (grant_id == CW'(i));
            head_sel[i] = !fifo_empty && (head_id == CW'(i));
            if (grant_id == CW'(i)) begin
                tx_command = cl_tx_command[i*CMD_BITS +: CMD_BITS];
                tx_data    = cl_tx_data[i*IO_BITS +: IO_BITS];
                valid_sel  = cl_tx_command_valid[i];
                reply_sel  = cl_reply_wanted[i];
            end
        end
    end

    assign tx_command_valid = valid_sel & ~fifo_full;

    assign cl_tx_command_started = {NUM_CLIENTS{tx_command_started}} & gnt_sel;
    assign cl_tx_active          = {NUM_CLIENTS{tx_active}}          & gnt_sel;
    assign cl_tx_data_next       = {NUM_CLIENTS{tx_data_next}}       & gnt_sel;
    assign cl_tx_done            = {NUM_CLIENTS{tx_done}}            & gnt_sel;

    assign cl_rx_started    = {NUM_CLIENTS{rx_started}}    & head_sel;
    assign cl_rx_active     = {NUM_CLIENTS{rx_active}}     & head_sel;
    assign cl_rx_sbs_valid  = {NUM_CLIENTS{rx_sbs_valid}}  & head_sel;
    assign cl_rx_data_valid = {NUM_CLIENTS{rx_data_valid}} & head_sel;
    assign cl_rx_done       = {NUM_CLIENTS{rx_done}}       & head_sel;

    // Reply-ID FIFO: a push into an empty FIFO only becomes the head on the following cycle.
    assign fifo_empty  = (count_q == 4'd0);
    assign fifo_full   = (count_q == 4'(MAX_OUTSTANDING));
    assign outstanding = count_q;
    assign head_id     = fifo_mem[rd_ptr_q];
    assign pop         = rx_done & ~fifo_empty;
    assign push        = tx_command_started & reply_sel & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= grant_id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q   <= DEF_ID;
            rr_ptr_q  <= DEF_ID;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
            rx_orphan <= 1'b0;
        end else begin
            if (!locked) grant_q <= sel_id;
            if (tx_command_started) rr_ptr_q <= grant_id;
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
            if (rx_started && fifo_empty) rx_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with random clients and a random memory model;
// a scoreboard of per-cycle expectations and TX/RX events is checked by a separate monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int CB = 3;
    localparam int IB = 2;
    localparam int MO = 7;

    typedef struct packed {
        logic [1:0]          gid;
        logic                tvld;
        logic [CB-1:0]       tcmd;
        logic [IB-1:0]       tdat;
        logic [3:0][N-1:0]   ctx;
        logic [4:0][N-1:0]   crx;
        logic [3:0]          outst;
        logic                full;
        logic                orph;
    } stat_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [CB-1:0] cmd;
        logic [IB-1:0] dat;
    } tx_ev_t;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    c_vld [2];
    logic [N-1:0]    c_rep [2];
    logic [N-1:0]    c_res [2];
    logic [N*CB-1:0] c_cmd [2];
    logic [N*IB-1:0] c_dat [2];
    logic t_st [2], t_act [2], t_nx [2], t_dn [2];
    logic r_st [2], r_act [2], r_sbs [2], r_dv [2], r_dn [2];

    logic          o_tvld [2];
    logic [CB-1:0] o_tcmd [2];
    logic [IB-1:0] o_tdat [2];
    logic [N-1:0]  o_cts [2], o_cta [2], o_ctn [2], o_ctd [2];
    logic [N-1:0]  o_crs [2], o_cra [2], o_crb [2], o_crv [2], o_crd [2];
    logic [1:0]    o_gid [2];
    logic [3:0]    o_out [2];
    logic          o_full [2], o_orph [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .NUM_CLIENTS(N), .IO_BITS(IB), .CMD_BITS(CB), .MAX_OUTSTANDING(MO),
            .RR_MODE(g), .DEFAULT_CLIENT(g == 0 ? 1 : 0)
        ) dut (
            .clk(clk), .reset(rst),
            .cl_tx_command_valid(c_vld[g]), .cl_tx_command(c_cmd[g]), .cl_tx_data(c_dat[g]),
            .cl_reply_wanted(c_rep[g]), .cl_reserve(c_res[g]),
            .tx_command_valid(o_tvld[g]), .tx_command(o_tcmd[g]), .tx_data(o_tdat[g]),
            .tx_command_started(t_st[g]), .tx_active(t_act[g]), .tx_data_next(t_nx[g]), .tx_done(t_dn[g]),
            .rx_started(r_st[g]), .rx_active(r_act[g]), .rx_sbs_valid(r_sbs[g]),
            .rx_data_valid(r_dv[g]), .rx_done(r_dn[g]),
            .cl_tx_command_started(o_cts[g]), .cl_tx_active(o_cta[g]),
            .cl_tx_data_next(o_ctn[g]), .cl_tx_done(o_ctd[g]),
            .cl_rx_started(o_crs[g]), .cl_rx_active(o_cra[g]), .cl_rx_sbs_valid(o_crb[g]),
            .cl_rx_data_valid(o_crv[g]), .cl_rx_done(o_crd[g]),
            .grant_id(o_gid[g]), .outstanding(o_out[g]), .fifo_full(o_full[g]), .rx_orphan(o_orph[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model state, one copy per DUT (0 = fixed priority, 1 = round robin).
    int     own [2];
    int     ptr [2];
    int     rq [2][$];
    bit     orph [2];
    bit     pend [2][N];
    int     p_cmd [2][N];
    int     p_dat [2][N];
    bit     p_rep [2][N];
    int     res_cnt [2][N];
    int     tx_left [2];
    int     rx_left [2];
    int     rx_len [2];

    stat_t  sq [2][$];
    tx_ev_t txq [2][$];
    int     rxq [2][$];

    int n_chk;
    int n_fail;

    function automatic int def_of(int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int pick(int d, logic [N-1:0] w);
        int c;
        if (d == 0) begin
            for (int i = N - 1; i >= 0; i--) if (w[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (ptr[d] + k) % N;
                if (w[c]) return c;
            end
        end
        return def_of(d);
    endfunction

    task automatic model_reset(int d);
        own[d]  = def_of(d);
        ptr[d]  = def_of(d);
        rq[d].delete();
        orph[d] = 1'b0;
    endtask

    task automatic chk(int d, string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
        end
    endtask

    task automatic step_dut(int d, bit in_rst, bit req_en, int rep_pct, bit tx_en, bit rx_en, bit orph_go);
        logic [N-1:0]    vld, res, rep, w, oh, hoh;
        logic [N*CB-1:0] cmdv;
        logic [N*IB-1:0] datv;
        bit    locked, empty, full, tvalid, tstart, tact, tnext, tdone;
        bit    rs, ra, rb, rv, rd, popped;
        int    sel, g, head;
        stat_t s;

        if (in_rst) model_reset(d);
        for (int i = 0; i < N; i++) begin
            if (!in_rst && req_en && !pend[d][i] && $urandom_range(3) == 0) begin
                pend[d][i]  = 1'b1;
                p_cmd[d][i] = int'($urandom_range(7));
                p_dat[d][i] = int'($urandom_range(3));
                p_rep[d][i] = (int'($urandom_range(99)) < rep_pct);
            end
            if (!in_rst && req_en && res_cnt[d][i] == 0 && $urandom_range(59) == 0)
                res_cnt[d][i] = int'($urandom_range(20, 4));
            vld[i] = pend[d][i];
            res[i] = (res_cnt[d][i] > 0);
            rep[i] = p_rep[d][i];
            cmdv[i*CB +: CB] = CB'(p_cmd[d][i]);
            datv[i*IB +: IB] = IB'(p_dat[d][i]);
        end

        tact  = (tx_left[d] > 0);
        tnext = tact && ($urandom_range(1) == 1);
        tdone = (tx_left[d] == 1);

        w      = vld | res;
        locked = tact || res[own[d]];
        sel    = pick(d, w);
        g      = locked ? own[d] : sel;
        full   = (rq[d].size() == MO);
        empty  = (rq[d].size() == 0);
        head   = empty ? 0 : rq[d][0];
        tvalid = vld[g] && !full;
        tstart = !in_rst && tx_en && !tact && tvalid && ($urandom_range(1) == 1);

        if (rx_left[d] == 0 && !in_rst && ((rx_en && !empty) || (orph_go && empty)) &&
            $urandom_range(2) == 0) begin
            rx_len[d]  = int'($urandom_range(5, 2));
            rx_left[d] = rx_len[d];
        end
        ra = (rx_left[d] > 0);
        rs = ra && (rx_left[d] == rx_len[d]);
        rb = ra && (rx_left[d] == rx_len[d] - 1);
        rv = ra && ($urandom_range(1) == 1);
        rd = (rx_left[d] == 1);

        c_vld[d] = vld;  c_res[d] = res;  c_rep[d] = rep;
        c_cmd[d] = cmdv; c_dat[d] = datv;
        t_st[d] = tstart; t_act[d] = tact; t_nx[d] = tnext; t_dn[d] = tdone;
        r_st[d] = rs; r_act[d] = ra; r_sbs[d] = rb; r_dv[d] = rv; r_dn[d] = rd;

        oh  = N'(1) << g;
        hoh = empty ? '0 : N'(1) << head;
        s.gid    = 2'(g);
        s.tvld   = tvalid;
        s.tcmd   = CB'(p_cmd[d][g]);
        s.tdat   = IB'(p_dat[d][g]);
        s.ctx[0] = tstart ? oh : '0;
        s.ctx[1] = tact   ? oh : '0;
        s.ctx[2] = tnext  ? oh : '0;
        s.ctx[3] = tdone  ? oh : '0;
        s.crx[0] = rs ? hoh : '0;
        s.crx[1] = ra ? hoh : '0;
        s.crx[2] = rb ? hoh : '0;
        s.crx[3] = rv ? hoh : '0;
        s.crx[4] = rd ? hoh : '0;
        s.outst  = 4'(rq[d].size());
        s.full   = full;
        s.orph   = orph[d];
        sq[d].push_back(s);
        if (tstart) txq[d].push_back('{id: 2'(g), cmd: CB'(p_cmd[d][g]), dat: IB'(p_dat[d][g])});
        if (rs && !empty) rxq[d].push_back(head);

        if (!in_rst) begin
            if (!locked) own[d] = sel;
            if (tstart) ptr[d] = g;
            popped = 1'b0;
            if (rd && !empty) begin
                void'(rq[d].pop_front());
                popped = 1'b1;
            end
            if (tstart && rep[g] && (!full || popped)) rq[d].push_back(g);
            if (rs && empty) orph[d] = 1'b1;
        end
        if (tx_left[d] > 0) tx_left[d]--;
        if (rx_left[d] > 0) rx_left[d]--;
        if (tstart) begin
            pend[d][g] = 1'b0;
            tx_left[d] = int'($urandom_range(5, 2));
        end
        for (int i = 0; i < N; i++) if (res_cnt[d][i] > 0) res_cnt[d][i]--;
        if (in_rst) begin
            tx_left[d] = 0;
            rx_left[d] = 0;
        end
    endtask

    // Monitor: pops per-cycle expectations and TX/RX events whenever the DUTs present them.
    initial begin
        stat_t  s;
        tx_ev_t e;
        int     h;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                while (sq[d].size() > 0) begin
                    s = sq[d].pop_front();
                    chk(d, "grant_id", 32'(o_gid[d]), 32'(s.gid));
                    chk(d, "tx_command_valid", 32'(o_tvld[d]), 32'(s.tvld));
                    chk(d, "tx_command", 32'(o_tcmd[d]), 32'(s.tcmd));
                    chk(d, "tx_data", 32'(o_tdat[d]), 32'(s.tdat));
                    chk(d, "cl_tx_command_started", 32'(o_cts[d]), 32'(s.ctx[0]));
                    chk(d, "cl_tx_active", 32'(o_cta[d]), 32'(s.ctx[1]));
                    chk(d, "cl_tx_data_next", 32'(o_ctn[d]), 32'(s.ctx[2]));
                    chk(d, "cl_tx_done", 32'(o_ctd[d]), 32'(s.ctx[3]));
                    chk(d, "cl_rx_started", 32'(o_crs[d]), 32'(s.crx[0]));
                    chk(d, "cl_rx_active", 32'(o_cra[d]), 32'(s.crx[1]));
                    chk(d, "cl_rx_sbs_valid", 32'(o_crb[d]), 32'(s.crx[2]));
                    chk(d, "cl_rx_data_valid", 32'(o_crv[d]), 32'(s.crx[3]));
                    chk(d, "cl_rx_done", 32'(o_crd[d]), 32'(s.crx[4]));
                    chk(d, "outstanding", 32'(o_out[d]), 32'(s.outst));
                    chk(d, "fifo_full", 32'(o_full[d]), 32'(s.full));
                    chk(d, "rx_orphan", 32'(o_orph[d]), 32'(s.orph));
                end
                if (|o_cts[d]) begin
                    if (txq[d].size() == 0) begin
                        chk(d, "tx_start_unexpected", 32'(o_cts[d]), 32'd0);
                    end else begin
                        e = txq[d].pop_front();
                        chk(d, "tx_event_owner", 32'(o_cts[d]), 32'(N'(1) << e.id));
                        chk(d, "tx_event_cmd", 32'(o_tcmd[d]), 32'(e.cmd));
                        chk(d, "tx_event_data", 32'(o_tdat[d]), 32'(e.dat));
                    end
                end
                if (|o_crs[d]) begin
                    if (rxq[d].size() == 0) begin
                        chk(d, "rx_route_unexpected", 32'(o_crs[d]), 32'd0);
                    end else begin
                        h = rxq[d].pop_front();
                        chk(d, "rx_event_route", 32'(o_crs[d]), 32'(N'(1) << h));
                    end
                end
            end
        end
    end

    initial begin
        bit in_rst, rst_done, req_en, tx_en, rx_en, orph_go;
        int rep_pct;
        n_chk    = 0;
        n_fail   = 0;
        rst_done = 1'b0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            tx_left[d] = 0; rx_left[d] = 0; rx_len[d] = 0;
            c_vld[d] = '0; c_res[d] = '0; c_rep[d] = '0; c_cmd[d] = '0; c_dat[d] = '0;
            t_st[d] = 0; t_act[d] = 0; t_nx[d] = 0; t_dn[d] = 0;
            r_st[d] = 0; r_act[d] = 0; r_sbs[d] = 0; r_dv[d] = 0; r_dn[d] = 0;
            for (int i = 0; i < N; i++) begin
                pend[d][i] = 0; p_cmd[d][i] = 0; p_dat[d][i] = 0; p_rep[d][i] = 0; res_cnt[d][i] = 0;
            end
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            req_en  = 1'b1; tx_en = 1'b1; rx_en = 1'b1; orph_go = 1'b0; rep_pct = 50;
            in_rst  = (cyc < 3);
            if (cyc >= 1500 && cyc < 1900) begin
                rep_pct = 100;
                rx_en   = 1'b0;
            end
            if (cyc >= 1900 && cyc < 2400) begin
                req_en  = 1'b0;
                tx_en   = 1'b0;
                orph_go = (cyc >= 2100);
            end
            if (cyc >= 3400 && !rst_done && (t_act[0] || cyc == 3599)) begin
                in_rst   = 1'b1;
                rst_done = 1'b1;
            end
            rst = in_rst;
            for (int d = 0; d < 2; d++) step_dut(d, in_rst, req_en, rep_pct, tx_en, rx_en, orph_go);
        end

        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "tx_events_left", 32'(txq[d].size()), 32'd0);
            chk(d, "rx_events_left", 32'(rxq[d].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
